// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned MULDIV_ITERATIONS = 32;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } muldiv_state_e;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the 64-bit working register: shift-add multiply or restoring divide.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] next_acc
);

  logic [32:0] sum;
  logic [32:0] rem_shift;
  logic [31:0] diff;
  logic        ge;

  always_comb begin
    sum       = {1'b0, acc[63:32]} + {1'b0, operand};
    // Divide: {remainder, dividend} shifted left one bit, top 33 bits are the trial remainder.
    rem_shift = acc[63:31];
    ge        = rem_shift >= {1'b0, operand};
    diff      = rem_shift[31:0] - operand;
    if (is_div) begin
      next_acc = {(ge ? diff : rem_shift[31:0]), acc[30:0], ge};
    end else if (acc[0]) begin
      next_acc = {sum, acc[31:1]};
    end else begin
      next_acc = {1'b0, acc[63:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and pipeline stall control.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        startInput,
  input  logic [1:0]  opInput,
  input  logic [31:0] operandAInput,
  input  logic [31:0] operandBInput,
  input  logic        writeHiInput,
  input  logic        writeLoInput,
  input  logic [31:0] writeDataInput,
  output logic        stallOutput,
  output logic        busyOutput,
  output logic        doneOutput,
  output logic        divByZeroOutput,
  output logic [31:0] hiOutput,
  output logic [31:0] loOutput
);

  localparam int unsigned CntW = $clog2(MULDIV_ITERATIONS);
  localparam logic [CntW-1:0] LastCnt = CntW'(MULDIV_ITERATIONS - 1);

  muldiv_state_e   state_q;
  muldiv_op_e      op_q;
  muldiv_op_e      op_in;
  logic [CntW-1:0] count_q;
  logic [63:0]     acc_q;
  logic [63:0]     acc_step;
  logic [31:0]     operand_q;
  logic [31:0]     raw_a_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic            neg_res_q;
  logic            neg_rem_q;
  logic            div0_q;

  logic            in_signed;
  logic            in_div;
  logic            run_div;
  logic [63:0]     prod_fix;
  logic [31:0]     quot_fix;
  logic [31:0]     rem_fix;
  logic [31:0]     hi_res;
  logic [31:0]     lo_res;

  assign op_in     = muldiv_op_e'(opInput);
  assign in_signed = (op_in == OpMult) || (op_in == OpDiv);
  assign in_div    = (op_in == OpDiv) || (op_in == OpDivu);
  assign run_div   = (op_q == OpDiv) || (op_q == OpDivu);

  muldiv_step u_step (
    .is_div   (run_div),
    .acc      (acc_q),
    .operand  (operand_q),
    .next_acc (acc_step)
  );

  always_comb begin
    prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    quot_fix = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    if (!run_div) begin
      {hi_res, lo_res} = prod_fix;
    end else if (div0_q) begin
      hi_res = raw_a_q;
      lo_res = 32'hFFFF_FFFF;
    end else begin
      hi_res = rem_fix;
      lo_res = quot_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= OpMult;
      count_q   <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      raw_a_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (startInput) begin
            op_q      <= op_in;
            count_q   <= '0;
            acc_q     <= {32'd0, abs_if(operandAInput, in_signed)};
            operand_q <= abs_if(operandBInput, in_signed);
            raw_a_q   <= operandAInput;
            neg_res_q <= in_signed && (operandAInput[31] ^ operandBInput[31]);
            neg_rem_q <= in_signed && operandAInput[31];
            div0_q    <= in_div && (operandBInput == 32'd0);
            state_q   <= StRun;
          end else begin
            if (writeHiInput) hi_q <= writeDataInput;
            if (writeLoInput) lo_q <= writeDataInput;
          end
        end
        StRun: begin
          acc_q   <= acc_step;
          count_q <= count_q + 1'b1;
          if (count_q == LastCnt) state_q <= StDone;
        end
        StDone: begin
          // Results commit on the edge leaving DONE so a reset during DONE discards them.
          hi_q    <= hi_res;
          lo_q    <= lo_res;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stallOutput     = (state_q == StRun) || ((state_q == StIdle) && startInput);
  assign busyOutput      = (state_q == StRun) || (state_q == StDone);
  assign doneOutput      = (state_q == StDone);
  assign divByZeroOutput = doneOutput && div0_q;
  assign hiOutput        = hi_q;
  assign loOutput        = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Ports SHALL be exactly as follows; one clock, and reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- startInput  in  1  EX-stage mult/div request; held while stalled.
- opInput  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operandAInput  in  32  multiplicand / dividend (forwarded Rs).
- operandBInput  in  32  multiplier / divisor (forwarded Rt).
- writeHiInput  in  1  MTHI request.
- writeLoInput  in  1  MTLO request.
- writeDataInput  in  32  MTHI/MTLO data.
- stallOutput  out  1  holds IF/ID/EX while high.
- busyOutput  out  1  high in RUN or DONE.
- doneOutput  out  1  one-cycle completion pulse.
- divByZeroOutput  out  1  pulses with doneOutput on DIV/DIVU with B=0.
- hiOutput  out  32  HI register.
- loOutput  out  32  LO register.

Function
REQ-002 FSM states SHALL be IDLE, RUN and DONE.
REQ-003 In IDLE with startInput=1, the block SHALL latch op, operand magnitudes and result signs, clear the iteration counter and go to RUN.
REQ-004 RUN SHALL last exactly 32 cycles, one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, counter 0..31, then go to DONE.
REQ-005 In DONE, HI/LO SHALL be loaded with sign-corrected results, doneOutput=1 for that cycle, and the next state SHALL be IDLE unconditionally.
REQ-006 stallOutput SHALL be combinational: (state==RUN) or (state==IDLE and startInput); it SHALL be low in DONE, so the instruction is stalled 33 cycles and leaves EX in the DONE cycle.
REQ-007 startInput SHALL be ignored in RUN and DONE; a start seen in IDLE after DONE is a new operation (back-to-back allowed).
REQ-008 MULT/MULTU: {HI,LO} SHALL be the 64-bit signed/unsigned product.
REQ-009 DIV/DIVU: LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
REQ-010 Divide by zero: LO=0xFFFFFFFF, HI=dividend (raw operandA), divByZeroOutput=1 in DONE; the block SHALL still take the full 32-cycle latency.
REQ-011 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-012 MTHI/MTLO SHALL write HI/LO on the next edge only in IDLE with startInput=0; they SHALL be ignored in RUN/DONE; start wins over a simultaneous write in IDLE.
REQ-013 writeHiInput and writeLoInput together SHALL write writeDataInput to both registers.
REQ-014 Operands SHALL be sampled only at start; changes during RUN SHALL have no effect.
REQ-015 hiOutput/loOutput SHALL be register outputs and SHALL hold their old values until the DONE edge.

Reset
REQ-016 Reset SHALL force IDLE, counter=0, HI=LO=0 and all internal working registers to 0.
REQ-017 After reset, stallOutput, busyOutput, doneOutput and divByZeroOutput SHALL be 0; stallOutput then follows REQ-006.
REQ-018 Reset asserted in RUN or DONE SHALL abort the operation; no doneOutput and no HI/LO update SHALL occur.

Structure
REQ-019 A shared package muldiv_pkg SHALL hold the op encoding enum, the state enum, and the constant MULDIV_ITERATIONS=32.
REQ-020 The per-cycle arithmetic step (shift-add / shift-subtract on the 64-bit working register) SHALL be a combinational sub-module muldiv_step; the FSM, counter, sign fix-up and HI/LO SHALL live in muldiv_sequencer.

Verification
REQ-021 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> stall high 33 cycles from start; done on cycle 33; HI=0xFFFFFFFE, LO=0x00000001.
REQ-022 MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
REQ-023 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 -> LO=3, HI=1; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-024 DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, divByZeroOutput=1 coincident with doneOutput.
REQ-025 Reset on RUN cycle 10 of MULTU 3x4 -> next cycle IDLE, stall=0, HI=LO=0, no done pulse.
REQ-026 MTHI 0x1234 during RUN -> ignored; MTLO 0xABCD in IDLE -> LO=0xABCD next cycle; start plus MTHI together in IDLE -> write dropped.
